// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: load-size encoding, write-back FSM
// states and common widths/constants.
package mips_pkg;

    localparam int          DATA_W   = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // Encoding 2'd3 is reserved and handled as a word load.
    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_t;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_result_stage_if.sv
// Write-back stage bus bundle.
//   in_*   : EX/MEM instruction handshake (in_ready flows back upstream)
//   mem_*  : data-memory read return
//   rf_*   : register-file write port
//   fwd_*  : forwarding tap to the ALU operand muxes (mirror of rf_*)
// master = upstream/memory side, slave = the write-back stage.
interface wb_result_stage_if;
    import mips_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_flush;
    logic [DATA_W-1:0] in_alu_result;
    logic [4:0]        in_rd;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [1:0]        in_ld_size;
    logic              in_ld_unsigned;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output in_valid, in_flush, in_alu_result, in_rd, in_reg_write,
               in_mem_to_reg, in_ld_size, in_ld_unsigned, mem_rdata, mem_rvalid,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  in_valid, in_flush, in_alu_result, in_rd, in_reg_write,
               in_mem_to_reg, in_ld_size, in_ld_unsigned, mem_rdata, mem_rvalid,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
    );

endinterface

// File: rtl/wb_result_stage_load_extract.sv
// Combinational load data extraction for a big-endian (MIPS) memory.
//   rdata       : aligned 32-bit read word
//   size        : LD_BYTE / LD_HALF / LD_WORD (reserved code = word)
//   offset      : address bits [1:0]
//   is_unsigned : zero-extend instead of sign-extend
//   result      : extended load value
module load_extract
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Byte offset 0 lives in the most significant lane.
        case (offset)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase

        half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

        case (size)
            LD_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            LD_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_result_stage.sv
// Write-back stage: selects ALU result or extracted load data, drives the
// register-file write port and forwarding tap, and stalls upstream while a
// load is outstanding (abandoned after TIMEOUT cycles, flagged sticky).
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : wb_result_stage_if.slave (in_*, mem_*, rf_*, fwd_*)
//   err_timeout : sticky load-timeout flag
//   retired     : count of completed, non-flushed instructions
module wb_result_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_result_stage_if.slave   bus,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    wb_state_t         state, state_nxt;
    logic [7:0]        wait_cnt, wait_cnt_nxt;

    logic [4:0]        p_rd;
    logic              p_reg_write;
    logic [1:0]        p_size;
    logic              p_unsigned;
    logic [1:0]        p_offset;

    logic              accept;
    logic              wr_fire;
    logic              wr_load;
    logic              wr_en_raw;
    logic [4:0]        wr_rd;
    logic              capture;
    logic              timeout_hit;

    logic [1:0]        ex_size;
    logic [1:0]        ex_offset;
    logic              ex_unsigned;
    logic [DATA_W-1:0] ex_result;

    logic              rf_we_q;
    logic [4:0]        rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    assign accept = bus.in_valid & ~bus.in_flush & (state == IDLE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        wr_fire      = 1'b0;
        wr_load      = 1'b0;
        wr_rd        = bus.in_rd;
        wr_en_raw    = bus.in_reg_write;
        capture      = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus.in_mem_to_reg) begin
                        wr_fire = 1'b1;
                    end else if (bus.mem_rvalid) begin
                        wr_fire = 1'b1;
                        wr_load = 1'b1;
                    end else begin
                        capture      = 1'b1;
                        wait_cnt_nxt = 8'd0;
                        state_nxt    = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                wr_rd     = p_rd;
                wr_en_raw = p_reg_write;
                if (bus.in_flush) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 8'd0;
                end else if (bus.mem_rvalid) begin
                    wr_fire      = 1'b1;
                    wr_load      = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit  = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Same-cycle loads use the live inputs; delayed loads use the captured copy.
    assign ex_size     = (state == WAIT_LOAD) ? p_size     : bus.in_ld_size;
    assign ex_offset   = (state == WAIT_LOAD) ? p_offset   : bus.in_alu_result[1:0];
    assign ex_unsigned = (state == WAIT_LOAD) ? p_unsigned : bus.in_ld_unsigned;

    load_extract u_load_extract (
        .rdata       (bus.mem_rdata),
        .size        (ex_size),
        .offset      (ex_offset),
        .is_unsigned (ex_unsigned),
        .result      (ex_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            p_rd        <= '0;
            p_reg_write <= 1'b0;
            p_size      <= '0;
            p_unsigned  <= 1'b0;
            p_offset    <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            err_timeout <= 1'b0;
            retired     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (capture) begin
                p_rd        <= bus.in_rd;
                p_reg_write <= bus.in_reg_write;
                p_size      <= bus.in_ld_size;
                p_unsigned  <= bus.in_ld_unsigned;
                p_offset    <= bus.in_alu_result[1:0];
            end
            // $zero is never written, but the instruction still retires.
            rf_we_q <= wr_fire & wr_en_raw & (wr_rd != REG_ZERO);
            if (wr_fire) begin
                rf_waddr_q <= wr_rd;
                rf_wdata_q <= wr_load ? ex_result : bus.in_alu_result;
                retired    <= retired + CNT_W'(1);
            end
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.fwd_valid = rf_we_q;
    assign bus.fwd_rd    = rf_waddr_q;
    assign bus.fwd_data  = rf_wdata_q;

endmodule

// File: tb/tb_wb_result_stage.sv
module tb_wb_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_timeout;
    logic [31:0] retired;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    wb_result_stage_if bus ();

    wb_result_stage #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_timeout (err_timeout),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid       = 1'b0;
        bus.in_flush       = 1'b0;
        bus.in_alu_result  = 32'h0;
        bus.in_rd          = 5'd0;
        bus.in_reg_write   = 1'b0;
        bus.in_mem_to_reg  = 1'b0;
        bus.in_ld_size     = 2'd0;
        bus.in_ld_unsigned = 1'b0;
        bus.mem_rdata      = 32'h0;
        bus.mem_rvalid     = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd,
                              input logic [1:0] size, input logic uns,
                              input logic rvalid, input logic [31:0] rdata);
        bus.in_valid       = 1'b1;
        bus.in_mem_to_reg  = 1'b1;
        bus.in_reg_write   = 1'b1;
        bus.in_alu_result  = addr;
        bus.in_rd          = rd;
        bus.in_ld_size     = size;
        bus.in_ld_unsigned = uns;
        bus.mem_rvalid     = rvalid;
        bus.mem_rdata      = rdata;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %h exp 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL reset_we got %h exp 0", bus.rf_we); else pass_cnt++;
        total_cnt++; if (bus.rf_waddr !== 5'd0) $display("FAIL reset_waddr got %h exp 0", bus.rf_waddr); else pass_cnt++;
        total_cnt++; if (bus.rf_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", bus.rf_wdata); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL reset_err got %h exp 0", err_timeout); else pass_cnt++;
        total_cnt++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d exp 0", retired); else pass_cnt++;
    endtask

    task automatic test_alu_write();
        bus.in_valid      = 1'b1;
        bus.in_mem_to_reg = 1'b0;
        bus.in_reg_write  = 1'b1;
        bus.in_rd         = 5'd5;
        bus.in_alu_result = 32'h0000_1234;
        step();
        idle_inputs();
        total_cnt++; if (bus.rf_we !== 1'b1) $display("FAIL alu_we got %h exp 1", bus.rf_we); else pass_cnt++;
        total_cnt++; if (bus.rf_waddr !== 5'd5) $display("FAIL alu_waddr got %0d exp 5", bus.rf_waddr); else pass_cnt++;
        total_cnt++; if (bus.rf_wdata !== 32'h0000_1234) $display("FAIL alu_wdata got %h exp 00001234", bus.rf_wdata); else pass_cnt++;
        total_cnt++; if (bus.fwd_valid !== 1'b1) $display("FAIL alu_fwd_valid got %h exp 1", bus.fwd_valid); else pass_cnt++;
        total_cnt++; if (bus.fwd_rd !== 5'd5) $display("FAIL alu_fwd_rd got %0d exp 5", bus.fwd_rd); else pass_cnt++;
        total_cnt++; if (bus.fwd_data !== 32'h0000_1234) $display("FAIL alu_fwd_data got %h exp 00001234", bus.fwd_data); else pass_cnt++;
        total_cnt++; if (retired !== 32'd1) $display("FAIL alu_retired got %0d exp 1", retired); else pass_cnt++;
        step();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL alu_we_pulse got %h exp 0", bus.rf_we); else pass_cnt++;
    endtask

    task automatic test_zero_latency_load();
        logic [31:0] exp_data [6] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'h0000_3344,
                                      32'h0000_11F2, 32'hFFFF_8000, 32'h8000_1234};
        logic [31:0] rdata    [6] = '{32'h11F2_3344, 32'h11F2_3344, 32'h11F2_3344,
                                      32'h11F2_3344, 32'h8000_1234, 32'h8000_1234};
        logic [1:0]  addr     [6] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [1:0]  size     [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
        logic        uns      [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive_load({30'h100, addr[i]}, 5'd7, size[i], uns[i], 1'b1, rdata[i]);
            step();
            idle_inputs();
            total_cnt++; if (bus.rf_we !== 1'b1) $display("FAIL zl_we[%0d] got %h exp 1", i, bus.rf_we); else pass_cnt++;
            total_cnt++; if (bus.rf_wdata !== exp_data[i]) $display("FAIL zl_wdata[%0d] got %h exp %h", i, bus.rf_wdata, exp_data[i]); else pass_cnt++;
            total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL zl_ready[%0d] got %h exp 1", i, bus.in_ready); else pass_cnt++;
            total_cnt++; if (retired !== 32'(2 + i)) $display("FAIL zl_retired[%0d] got %0d exp %0d", i, retired, 2 + i); else pass_cnt++;
        end
        step();
    endtask

    task automatic test_delayed_load();
        // retired is 7 on entry
        drive_load(32'h0000_2000, 5'd9, 2'd2, 1'b0, 1'b0, 32'h0);
        step();
        // held in_valid with a different rd must be ignored while waiting
        bus.in_rd         = 5'd20;
        bus.in_mem_to_reg = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL dl_ready_c%0d got %h exp 0", c, bus.in_ready); else pass_cnt++;
            total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL dl_we_c%0d got %h exp 0", c, bus.rf_we); else pass_cnt++;
            if (c == 3) begin
                idle_inputs();
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hDEAD_BEEF;
            end
            step();
        end
        idle_inputs();
        total_cnt++; if (bus.rf_we !== 1'b1) $display("FAIL dl_we got %h exp 1", bus.rf_we); else pass_cnt++;
        total_cnt++; if (bus.rf_waddr !== 5'd9) $display("FAIL dl_waddr got %0d exp 9", bus.rf_waddr); else pass_cnt++;
        total_cnt++; if (bus.rf_wdata !== 32'hDEAD_BEEF) $display("FAIL dl_wdata got %h exp deadbeef", bus.rf_wdata); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL dl_ready got %h exp 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (retired !== 32'd8) $display("FAIL dl_retired got %0d exp 8", retired); else pass_cnt++;
        step();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL dl_we_pulse got %h exp 0", bus.rf_we); else pass_cnt++;
    endtask

    task automatic test_timeout();
        drive_load(32'h0000_3000, 5'd10, 2'd2, 1'b0, 1'b0, 32'h0);
        step();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL to_ready_c%0d got %h exp 0", c, bus.in_ready); else pass_cnt++;
            total_cnt++; if (err_timeout !== 1'b0) $display("FAIL to_err_early_c%0d got %h exp 0", c, err_timeout); else pass_cnt++;
            step();
        end
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL to_ready_after got %h exp 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL to_we got %h exp 0", bus.rf_we); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b1) $display("FAIL to_err got %h exp 1", err_timeout); else pass_cnt++;
        total_cnt++; if (retired !== 32'd8) $display("FAIL to_retired got %0d exp 8", retired); else pass_cnt++;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        step();
        idle_inputs();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL to_late_we got %h exp 0", bus.rf_we); else pass_cnt++;
        total_cnt++; if (retired !== 32'd8) $display("FAIL to_late_retired got %0d exp 8", retired); else pass_cnt++;
        step();
        total_cnt++; if (err_timeout !== 1'b1) $display("FAIL to_err_held got %h exp 1", err_timeout); else pass_cnt++;
    endtask

    task automatic test_flush();
        drive_load(32'h0000_4000, 5'd11, 2'd2, 1'b0, 1'b0, 32'h0);
        step();
        idle_inputs();
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL fl_wait_ready got %h exp 0", bus.in_ready); else pass_cnt++;
        bus.in_flush   = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        step();
        idle_inputs();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL fl_we got %h exp 0", bus.rf_we); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL fl_ready got %h exp 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (retired !== 32'd8) $display("FAIL fl_retired got %0d exp 8", retired); else pass_cnt++;
        // flush in IDLE drops the presented instruction
        bus.in_valid      = 1'b1;
        bus.in_flush      = 1'b1;
        bus.in_reg_write  = 1'b1;
        bus.in_rd         = 5'd3;
        bus.in_alu_result = 32'h0000_0033;
        step();
        idle_inputs();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL fl_idle_we got %h exp 0", bus.rf_we); else pass_cnt++;
        total_cnt++; if (retired !== 32'd8) $display("FAIL fl_idle_retired got %0d exp 8", retired); else pass_cnt++;
    endtask

    task automatic test_rd_zero();
        bus.in_valid      = 1'b1;
        bus.in_reg_write  = 1'b1;
        bus.in_rd         = 5'd0;
        bus.in_alu_result = 32'h0000_0077;
        step();
        idle_inputs();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL rd0_we got %h exp 0", bus.rf_we); else pass_cnt++;
        total_cnt++; if (retired !== 32'd9) $display("FAIL rd0_retired got %0d exp 9", retired); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus.in_valid      = 1'b1;
        bus.in_reg_write  = 1'b1;
        bus.in_rd         = 5'd1;
        bus.in_alu_result = 32'hAAAA_0001;
        step();
        bus.in_rd         = 5'd2;
        bus.in_alu_result = 32'hBBBB_0002;
        total_cnt++; if (bus.rf_wdata !== 32'hAAAA_0001) $display("FAIL b2b_wdata0 got %h exp aaaa0001", bus.rf_wdata); else pass_cnt++;
        total_cnt++; if (bus.rf_waddr !== 5'd1) $display("FAIL b2b_waddr0 got %0d exp 1", bus.rf_waddr); else pass_cnt++;
        step();
        idle_inputs();
        total_cnt++; if (bus.rf_we !== 1'b1) $display("FAIL b2b_we1 got %h exp 1", bus.rf_we); else pass_cnt++;
        total_cnt++; if (bus.rf_wdata !== 32'hBBBB_0002) $display("FAIL b2b_wdata1 got %h exp bbbb0002", bus.rf_wdata); else pass_cnt++;
        total_cnt++; if (bus.rf_waddr !== 5'd2) $display("FAIL b2b_waddr1 got %0d exp 2", bus.rf_waddr); else pass_cnt++;
        total_cnt++; if (retired !== 32'd11) $display("FAIL b2b_retired got %0d exp 11", retired); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_wait();
        drive_load(32'h0000_5000, 5'd12, 2'd2, 1'b0, 1'b0, 32'h0);
        step();
        idle_inputs();
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rmw_wait_ready got %h exp 0", bus.in_ready); else pass_cnt++;
        rst_n          = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        step();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL rmw_we got %h exp 0", bus.rf_we); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rmw_ready got %h exp 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL rmw_err got %h exp 0", err_timeout); else pass_cnt++;
        total_cnt++; if (retired !== 32'd0) $display("FAIL rmw_retired got %0d exp 0", retired); else pass_cnt++;
        total_cnt++; if (bus.rf_waddr !== 5'd0) $display("FAIL rmw_waddr got %0d exp 0", bus.rf_waddr); else pass_cnt++;
        total_cnt++; if (bus.rf_wdata !== 32'h0) $display("FAIL rmw_wdata got %h exp 0", bus.rf_wdata); else pass_cnt++;
        rst_n = 1'b1;
        idle_inputs();
        step();
        total_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL rmw_after_we got %h exp 0", bus.rf_we); else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_write();
        test_zero_latency_load();
        test_delayed_load();
        test_timeout();
        test_flush();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
- Write-back end of the datapath. Accepts retiring instructions from the EX/MEM boundary and selects ALU result or load data (MemtoReg).
- Performs load byte/half extraction and sign or zero extension.
- Drives the register-file write port and a forwarding tap back to the ALU operand-select muxes.
- Absorbs variable data-memory load latency by stalling upstream, with a timeout guard.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_rvalid before abandoning a load (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX/MEM instruction present
- in_ready  out  1  stage can accept; 0 while waiting on a load
- in_flush  in  1  cancel pending load and drop this cycle's input
- in_alu_result  in  32  ALU result; load address when in_mem_to_reg=1
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_mem_to_reg  in  1  1 = write load data, 0 = write ALU result
- in_ld_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- in_ld_unsigned  in  1  zero-extend instead of sign-extend
- mem_rdata  in  32  data-memory read word, aligned
- mem_rvalid  in  1  mem_rdata valid this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- fwd_valid  out  1  equals rf_we; forwarding tap
- fwd_rd  out  5  equals rf_waddr
- fwd_data  out  32  equals rf_wdata
- err_timeout  out  1  sticky: a load timed out
- retired  out  CNT_W  count of accepted, non-flushed instructions completed

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, in_ready=1.
  - rf_we=0, rf_waddr=0, rf_wdata=0, err_timeout=0, retired=0, wait counter=0.
  - A reset mid-WAIT_LOAD abandons the load with no write.
- States: IDLE, WAIT_LOAD. in_ready = (state==IDLE), combinational.
- rf_we/rf_waddr/rf_wdata are registered. Every output pulse of rf_we lasts exactly one cycle.
- IDLE, accept = in_valid & ~in_flush:
  - ALU op (in_mem_to_reg=0): next cycle rf_we = in_reg_write & (in_rd!=0), rf_wdata=in_alu_result, rf_waddr=in_rd. Latency 1. retired+1.
  - Load with mem_rvalid=1 same cycle: write extracted data next cycle (latency 1), stay IDLE.
  - Load with mem_rvalid=0: capture rd, reg_write, size, unsigned flag, addr[1:0]. Go to WAIT_LOAD with counter=0.
- WAIT_LOAD:
  - in_valid is ignored; the upstream must hold.
  - mem_rvalid=1: write extracted data next cycle, retired+1, go to IDLE.
  - in_flush=1: go to IDLE, no write, no count. Flush wins over a simultaneous mem_rvalid.
  - Counter reaches TIMEOUT-1 without rvalid: go to IDLE, no write, set err_timeout. Only reset clears err_timeout.
- mem_rvalid in IDLE with no accepted load is ignored.
- Register 0 never written: rf_we forced 0 when rd==0. Such instructions still count as retired.
- Load extraction, big-endian byte lanes (MIPS): offset 0 = bits 31:24.
  - byte: lane = 3-addr[1:0].
  - half: addr[1]=0 selects bits 31:16, addr[1]=1 selects bits 15:0; addr[0] is ignored.
  - word: addr[1:0] is ignored.
  - Extension is sign or zero per in_ld_unsigned. Word is unaffected.
- retired wraps modulo 2^CNT_W.

Decomposition:
- Shared package (mips_pkg):
  - ld_size_t enum (LD_BYTE, LD_HALF, LD_WORD).
  - wb_state_t enum (IDLE, WAIT_LOAD).
  - REG_ZERO = 5'd0.
  - DATA_W = 32.
- Sub-module load_extract: purely combinational rdata/size/offset/unsigned -> 32-bit result. Reusable by the MEM stage and unit-testable alone.

Test Plan:
- ALU write: in_valid=1, mem_to_reg=0, rd=5, result=32'h0000_1234 -> next cycle rf_we=1, waddr=5, wdata=32'h0000_1234, fwd_* identical, retired=1.
- Zero-latency load, LB signed, addr=...01, mem_rdata=32'h11F2_3344, same-cycle rvalid -> next cycle wdata=32'hFFFF_FFF2. Repeat with unsigned -> 32'h0000_00F2. LH addr=...10 signed -> 32'h0000_3344.
- Delayed load: accept at cycle 0, rvalid at cycle 3 with 32'hDEAD_BEEF, LW -> in_ready=0 cycles 1-3, rf_we=1 at cycle 4 with 32'hDEADBEEF, in_ready=1 at cycle 4.
- Timeout: TIMEOUT=4, load with no rvalid -> in_ready low 4 cycles, then IDLE, no rf_we, err_timeout=1 and held. Late rvalid afterwards is ignored.
- Flush vs rvalid: in WAIT_LOAD assert in_flush and mem_rvalid in the same cycle -> no write, retired unchanged, IDLE next cycle.
- rd=0 ALU op -> rf_we stays 0, retired increments. Reset asserted mid-WAIT_LOAD -> all outputs return to reset values next cycle, no write.
